// File: rtl/instr_loader.sv
// Boot loader: takes a little-endian byte stream (word count N, then N words),
// writes each word into instruction memory, sends one ack byte, then holds done.
module instr_loader #(
  parameter int         DEPTH    = 32768,
  parameter logic [7:0] ACK_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic        overflow
);

  // LAST is the write-pulse cycle of the final word: no byte is taken there,
  // so nothing past the program can be swallowed before the ack goes out.
  typedef enum logic [2:0] {LEN, DATA, LAST, ACK, DONE} state_t;

  state_t      state;
  logic [1:0]  bidx;
  logic [31:0] word_idx;
  logic [31:0] n;
  logic [31:0] asm_w;
  logic        hs;
  logic [31:0] word;

  assign hs      = rx_valid && rx_ready;
  assign word    = {rx_data, asm_w[31:8]};
  assign tx_data = ACK_BYTE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN;
      bidx     <= 2'd0;
      word_idx <= 32'd0;
      n        <= 32'd0;
      asm_w    <= 32'd0;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= 32'd0;
      wdata    <= 32'd0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        LEN: begin
          rx_ready <= 1'b1;
          if (hs) begin
            asm_w <= word;
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              n        <= word;
              word_idx <= 32'd0;
              overflow <= overflow | (word > 32'(DEPTH));
              if (word == 32'd0) begin
                state    <= ACK;
                rx_ready <= 1'b0;
                tx_valid <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (hs) begin
            asm_w <= word;
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              // words past capacity are still counted, just not written
              we       <= (word_idx < 32'(DEPTH));
              waddr    <= {word_idx[29:0], 2'b00};
              wdata    <= word;
              word_idx <= word_idx + 32'd1;
              if (word_idx + 32'd1 == n) begin
                state    <= LAST;
                rx_ready <= 1'b0;
              end
            end
          end
        end
        LAST: begin
          state    <= ACK;
          tx_valid <= 1'b1;
        end
        ACK: begin
          if (tx_ready) begin
            state    <= DONE;
            tx_valid <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus random streams
// checked against a reference list of expected writes and ack timing.
module tb_instr_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic        overflow;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];

  instr_loader #(.DEPTH(DEPTH), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // capture every write pulse with the cycle it was seen in
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_t w;
      w.c = cyc; w.a = waddr; w.d = wdata;
      wq.push_back(w);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask

  // offers one byte after 'gap' idle cycles; returns the cycle of the handshake
  task automatic send_byte(input logic [7:0] b, input int gap, output int hc);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      errs++; checks++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
    end
    hc = cyc;
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, output int hc);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(maxgap, 0), hc);
  endtask

  // full stream from reset: header, words, ack handshake, then all checks
  task automatic run_stream(input string nm, input logic [31:0] words[$], input int maxgap,
                            input int hold);
    int          hc, t, tv_cyc, nexp;
    logic [31:0] nw;
    wr_t         e[$];
    nw = 32'(words.size());
    do_reset();
    send_word(nw, maxgap, hc);
    foreach (words[i]) begin
      send_word(words[i], maxgap, hc);
      if (i < DEPTH) begin
        wr_t x;
        x.c = hc + 1; x.a = 32'(i * 4); x.d = words[i];
        e.push_back(x);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    t = 0;
    while (tx_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    tv_cyc = cyc;
    nexp = (nw == 0) ? hc + 1 : hc + 2;
    checks++;
    if (tv_cyc !== nexp || tx_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s ack_cycle: tx_valid=%b at cycle %0d required at %0d", nm, tx_valid, tv_cyc, nexp);
    end
    checks++;
    if (tx_data !== 8'hAA) begin
      errs++; $display("FAIL %s tx_data: got %h required aa", nm, tx_data);
    end
    checks++;
    if (overflow !== (nw > DEPTH)) begin
      errs++; $display("FAIL %s overflow: got %b required %b", nm, overflow, nw > DEPTH);
    end
    for (int h = 0; h < hold; h++) begin
      checks++;
      if (tx_valid !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s ack_hold: tx_valid=%b done=%b rx_ready=%b required 1 0 0", nm, tx_valid, done, rx_ready);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s done: done=%b tx_valid=%b rx_ready=%b required 1 0 0", nm, done, tx_valid, rx_ready);
    end
    checks++;
    if (wq.size() !== e.size()) begin
      errs++; $display("FAIL %s write_count: got %0d required %0d", nm, wq.size(), e.size());
    end else begin
      foreach (e[i]) begin
        checks++;
        if (wq[i].c !== e[i].c || wq[i].a !== e[i].a || wq[i].d !== e[i].d) begin
          errs++;
          $display("FAIL %s write%0d: cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                   nm, i, wq[i].c, wq[i].a, wq[i].d, e[i].c, e[i].a, e[i].d);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || we !== 1'b0 || waddr !== 32'd0 || wdata !== 32'd0 ||
        tx_valid !== 1'b0 || tx_data !== 8'hAA || done !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset: rdy=%b we=%b wa=%h wd=%h txv=%b txd=%h done=%b ovf=%b required 0 0 0 0 0 aa 0 0",
               rx_ready, we, waddr, wdata, tx_valid, tx_data, done, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errs++; $display("FAIL reset_release: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] w[$];
    w = '{32'hDEADBEEF};
    run_stream("single", w, 1, 2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    w = '{32'h00000013, 32'h00100093, 32'hFFFFFFFF};
    run_stream("b2b", w, 0, 0);
  endtask

  task automatic test_zero();
    logic [31:0] w[$];
    run_stream("zero", w, 0, 5);
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    for (int i = 0; i < 6; i++) w.push_back($urandom);
    run_stream("overflow", w, 1, 1);
  endtask

  task automatic test_reset_mid();
    int          hc;
    logic [31:0] w[$];
    do_reset();
    send_word(32'd2, 0, hc);
    send_word(32'hCAFEF00D, 0, hc);
    send_byte(8'h11, 0, hc);
    send_byte(8'h22, 0, hc);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || waddr !== 32'd0 || wdata !== 32'd0 || rx_ready !== 1'b0 ||
        tx_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_values: we=%b wa=%h wd=%h rdy=%b txv=%b done=%b ovf=%b required all 0",
               we, waddr, wdata, rx_ready, tx_valid, done, overflow);
    end
    checks++;
    if (wq.size() !== 1) begin
      errs++; $display("FAIL reset_mid_writes: got %0d writes required 1", wq.size());
    end
    rst = 1'b0;
    w = '{32'h12345678};
    run_stream("after_reset", w, 0, 0);
  endtask

  task automatic test_after_done();
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || we !== 1'b0 || done !== 1'b1 || tx_valid !== 1'b0) begin
        errs++;
        $display("FAIL after_done: rdy=%b we=%b done=%b txv=%b required 0 0 1 0", rx_ready, we, done, tx_valid);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] w[$];
      int n;
      n = $urandom_range(7, 0);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_stream($sformatf("rand%0d", it), w, $urandom_range(2, 0), $urandom_range(4, 0));
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_overflow();
    test_reset_mid();
    test_after_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
